// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle for the iterative multiply/divide unit
// Purpose: groups the operation request (start/op/abort/a/b) and the result
//          (busy/done/div_zero/hi/lo) of mult_div_unit.
// Ports  : master drives the request and observes the result;
//          slave (the unit) observes the request and drives the result.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, abort, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, abort, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative one-bit-per-cycle signed/unsigned multiply and divide
// Purpose: MULT/MULTU produce the full 2*WIDTH product in {hi,lo}; DIV/DIVU
//          produce quotient in lo and remainder in hi (truncating toward zero).
// Ports  : clk   - clock, rising edge
//          reset - asynchronous active-low reset
//          bus   - mult_div_unit_if.slave (start/op/abort/a/b in,
//                  busy/done/div_zero/hi/lo out)
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateType;

  stateType         state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] accHi;      // mult: running upper half; div: partial remainder
  logic [WIDTH-1:0] accLo;      // mult: multiplier shifting out / product low; div: dividend in, quotient out
  logic [WIDTH-1:0] operand;    // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0] hiReg, loReg;
  logic             isDiv, negLo, negHi, dzPending, divZeroReg;

  logic             accept, finish, signedOp, quotBit;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum, divShift, divDiff;

  assign accept   = (state == IDLE) && bus.start && !bus.abort;
  assign finish   = (state == DONE) && !bus.abort;
  assign signedOp = ~bus.op[0];
  assign magA     = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB     = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shift-add step: conditional add into the upper half, then shift the
  // whole {carry, accHi, accLo} right by one.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);

  // Restoring divide step: bring the next dividend bit into the remainder and
  // keep the subtraction only when it did not borrow.
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand};
  assign quotBit  = ~divDiff[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = (bus.op[1] && (bus.b == '0)) ? DONE : CALC;
      CALC: if (bus.abort) nextState = IDLE;
            else if (cnt == CNT_W'(WIDTH - 1)) nextState = FIX;
      FIX:  nextState = bus.abort ? IDLE : DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      accHi      <= '0;
      accLo      <= '0;
      operand    <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      isDiv      <= 1'b0;
      negLo      <= 1'b0;
      negHi      <= 1'b0;
      dzPending  <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt        <= '0;
          accHi      <= '0;
          isDiv      <= bus.op[1];
          negLo      <= signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negHi      <= signedOp && bus.a[WIDTH-1];
          dzPending  <= bus.op[1] && (bus.b == '0);
          divZeroReg <= 1'b0;
          accLo      <= bus.op[1] ? magA : magB;
          operand    <= bus.op[1] ? magB : magA;
        end
        CALC: if (!bus.abort) begin
          cnt <= cnt + 1'b1;
          if (isDiv) begin
            accHi <= quotBit ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], quotBit};
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        FIX: if (!bus.abort) begin
          if (isDiv) begin
            accLo <= negLo ? -accLo : accLo;
            accHi <= negHi ? -accHi : accHi;
          end else if (negLo) begin
            {accHi, accLo} <= -{accHi, accLo};
          end
        end
        DONE: if (finish) begin
          // Committing on the way out of DONE lets an abort raised in DONE
          // still leave hi/lo/div_zero untouched.
          divZeroReg <= dzPending;
          if (!dzPending) begin
            hiReg <= accHi;
            loReg <= accLo;
          end
        end
        default: ;
      endcase
    end
  end

  // While DONE is being completed the fresh result is forwarded so that it is
  // visible in the same cycle as the done pulse.
  assign bus.busy     = (state != IDLE);
  assign bus.done     = finish;
  assign bus.div_zero = divZeroReg | (finish & dzPending);
  assign bus.hi       = (finish && !dzPending) ? accHi : hiReg;
  assign bus.lo       = (finish && !dzPending) ? accLo : loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [W-1:0] expHi, expLo;
  logic         expDz;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands. Divide-by-zero keeps hi/lo.
  task automatic modelOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   sa, sb;
    sa    = a;
    sb    = b;
    expDz = 1'b0;
    case (op)
      2'b00: begin sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}); {expHi, expLo} = sp; end
      2'b01: begin up = {{W{1'b0}}, a} * {{W{1'b0}}, b}; {expHi, expLo} = up; end
      2'b10: begin
        if (b == '0) expDz = 1'b1;
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin expLo = a; expHi = '0; end
        else begin expLo = sa / sb; expHi = sa % sb; end
      end
      default: begin
        if (b == '0) expDz = 1'b1;
        else begin expLo = a / b; expHi = a % b; end
      end
    endcase
  endtask

  // Launches one operation and measures the cycle of the done pulse
  // (1 = cycle right after the accepting edge).
  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz,
                       output int lat, output logic doneAfter, output logic busyAfter);
    logic got;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    lat = 0; got = 1'b0;
    hi = '0; lo = '0; dz = 1'b0;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin got = 1'b1; hi = bus.hi; lo = bus.lo; dz = bus.div_zero; end
    end
    @(negedge clk);
    doneAfter = bus.done;
    busyAfter = bus.busy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b exp=0", bus.div_zero); end
    checks++; if ({bus.hi, bus.lo} !== '0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", bus.hi, bus.lo); end
    reset = 1'b1;
    expHi = '0; expLo = '0; expDz = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]   ops [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [W-1:0] as  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7, 32'h80000000, 32'h12345678};
    logic [W-1:0] bs  [7] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2, 32'hFFFFFFFF, 32'h0};
    logic [W-1:0] hi, lo;
    logic dz, dAfter, bAfter;
    int lat;
    for (int i = 0; i < 7; i++) begin
      modelOp(ops[i], as[i], bs[i]);
      runOp(ops[i], as[i], bs[i], hi, lo, dz, lat, dAfter, bAfter);
      checks++; if (lat !== (expDz ? 1 : W + 2)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, expDz ? 1 : W + 2); end
      checks++; if ({hi, lo} !== {expHi, expLo}) begin failures++; $display("FAIL dir%0d_result got=%h_%h exp=%h_%h", i, hi, lo, expHi, expLo); end
      checks++; if (dz !== expDz) begin failures++; $display("FAIL dir%0d_div_zero got=%b exp=%b", i, dz, expDz); end
      checks++; if (dAfter !== 1'b0 || bAfter !== 1'b0) begin failures++; $display("FAIL dir%0d_after got done=%b busy=%b exp 0 0", i, dAfter, bAfter); end
      checks++; if (bus.div_zero !== expDz) begin failures++; $display("FAIL dir%0d_div_zero_hold got=%b exp=%b", i, bus.div_zero, expDz); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, hi, lo;
    logic [1:0] op;
    logic dz, dAfter, bAfter;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 5));
        2: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h1; end
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      modelOp(op, a, b);
      runOp(op, a, b, hi, lo, dz, lat, dAfter, bAfter);
      checks++;
      if ({hi, lo} !== {expHi, expLo} || dz !== expDz || lat !== (expDz ? 1 : W + 2)) begin
        failures++; bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h dz=%b lat=%0d exp=%h_%h dz=%b", i, op, a, b, hi, lo, dz, lat, expHi, expLo, expDz);
      end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] hi, lo;
    logic dz, dAfter, bAfter, sawDone;
    int lat;
    modelOp(2'b01, 32'h00010001, 32'h00000003);
    runOp(2'b01, 32'h00010001, 32'h00000003, hi, lo, dz, lat, dAfter, bAfter);
    checks++; if ({hi, lo} !== {expHi, expLo}) begin failures++; $display("FAIL abort_setup got=%h_%h exp=%h_%h", hi, lo, expHi, expLo); end
    // Abort during CALC, sampled at edge 10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hDEADBEEF; bus.b = 32'h55;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_calc_idle got busy=%b exp=0", bus.busy); end
    sawDone = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done) sawDone = 1'b1; end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("FAIL abort_calc_no_done got=%b exp=0", sawDone); end
    checks++; if ({bus.hi, bus.lo} !== {expHi, expLo}) begin failures++; $display("FAIL abort_calc_hold got=%h_%h exp=%h_%h", bus.hi, bus.lo, expHi, expLo); end
    // Abort while in DONE: no pulse, result not committed.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 100 && !bus.done) begin @(negedge clk); lat++; end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done_pulse got=%b exp=0 (lat=%0d)", bus.done, lat); end
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== {expHi, expLo}) begin
      failures++; $display("FAIL abort_done_hold got busy=%b %h_%h exp busy=0 %h_%h", bus.busy, bus.hi, bus.lo, expHi, expLo);
    end
    // Abort in IDLE beats start.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = 2'b00; bus.a = 32'h3; bus.b = 32'h3;
    @(posedge clk); #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_idle_priority got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic sawDone;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234; bus.b = 32'h5678;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || {bus.hi, bus.lo} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got busy=%b done=%b dz=%b %h_%h exp all 0", bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    @(negedge clk); reset = 1'b1;
    expHi = '0; expLo = '0; expDz = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) sawDone = 1'b1; end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done got=%b exp=0", sawDone); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, h1, l1, h2, l2;
    int doneAt[$];
    logic [W-1:0] his[$], los[$];
    int k;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    modelOp(2'b00, a2, b2); h2 = expHi; l2 = expLo;
    modelOp(2'b00, a1, b1); h1 = expHi; l1 = expLo;
    @(negedge clk);
    bus.op = 2'b00; bus.a = a1; bus.b = b1; bus.start = 1'b1;
    @(posedge clk); #1 begin bus.a = a2; bus.b = b2; end
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (bus.done) begin doneAt.push_back(i); his.push_back(bus.hi); los.push_back(bus.lo); end
    end
    bus.start = 1'b0;
    k = 0;
    while (k < 60 && bus.busy) begin @(negedge clk); k++; end
    expHi = h2; expLo = l2; expDz = 1'b0;
    checks++; if (doneAt.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", doneAt.size()); end
    if (doneAt.size() == 3) begin
      checks++; if (doneAt[0] !== 34 || doneAt[1] !== 69 || doneAt[2] !== 104) begin
        failures++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=34,69,104", doneAt[0], doneAt[1], doneAt[2]);
      end
      checks++; if ({his[0], los[0]} !== {h1, l1}) begin failures++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", his[0], los[0], h1, l1); end
      checks++; if ({his[1], los[1], his[2], los[2]} !== {h2, l2, h2, l2}) begin
        failures++; $display("FAIL b2b_second got=%h_%h %h_%h exp=%h_%h", his[1], los[1], his[2], los[2], h2, l2);
      end
    end
    checks++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== {h2, l2}) begin
      failures++; $display("FAIL b2b_drain got busy=%b %h_%h exp busy=0 %h_%h", bus.busy, bus.hi, bus.lo, h2, l2);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
